// File: rtl/counter_sched_pkg.sv
// Shared types for the counter_sched interval timer: FSM state encoding.
package counter_sched_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sched_state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Prescaler for counter_sched: raises step once every div+1 enabled cycles.
module tick_prescaler #(
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               clr,
    input  logic               en,
    input  logic [PRESC_W-1:0] div,
    output logic               step
);

    logic [PRESC_W-1:0] cnt_r;

    assign step = en && (cnt_r == div);

    // Prescaler count: clear wins over enable, wraps to zero on each step.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_r <= {PRESC_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {PRESC_W{1'b0}};
        end else if (en) begin
            if (cnt_r == div) begin
                cnt_r <= {PRESC_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + PRESC_W'(1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/counter_sched.sv
// Programmable interval timer: start/stop/hold sequencing, prescaled up-count,
// terminal-count tick with one-shot or auto-reload behaviour.
module counter_sched
    import counter_sched_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic               stop,
    input  logic               hold,
    input  logic               auto_reload,
    input  logic [WIDTH-1:0]   period,
    input  logic [PRESC_W-1:0] prescale,
    output logic [WIDTH-1:0]   count_out,
    output logic               busy,
    output logic               paused,
    output logic               tick,
    output logic               done
);

    sched_state_e       state_r;
    logic [WIDTH-1:0]   count_r;
    logic [WIDTH-1:0]   period_sh_r;
    logic [PRESC_W-1:0] presc_sh_r;
    logic               reload_sh_r;
    logic               busy_r;
    logic               paused_r;
    logic               tick_r;
    logic               done_r;
    logic               active_s;
    logic               step_s;

    // Leaving PAUSE counts on the same edge, so a hold of N cycles delays by exactly N.
    assign active_s = (state_r != IDLE) && !hold && !start && !stop;

    tick_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_presc (
        .clk  (clk),
        .rstn (rstn),
        .clr  (start),
        .en   (active_s),
        .div  (presc_sh_r),
        .step (step_s)
    );

    // Control FSM, main count, shadow config and registered status pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= IDLE;
            count_r     <= {WIDTH{1'b0}};
            period_sh_r <= {WIDTH{1'b0}};
            presc_sh_r  <= {PRESC_W{1'b0}};
            reload_sh_r <= 1'b0;
            busy_r      <= 1'b0;
            paused_r    <= 1'b0;
            tick_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            tick_r <= 1'b0;
            done_r <= 1'b0;
            if (stop) begin
                state_r  <= IDLE;
                busy_r   <= 1'b0;
                paused_r <= 1'b0;
            end else if (start) begin
                state_r     <= RUN;
                count_r     <= {WIDTH{1'b0}};
                period_sh_r <= period;
                presc_sh_r  <= prescale;
                reload_sh_r <= auto_reload;
                busy_r      <= 1'b1;
                paused_r    <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        state_r <= IDLE;
                    end
                    RUN, PAUSE: begin
                        if (hold) begin
                            state_r  <= PAUSE;
                            paused_r <= 1'b1;
                        end else begin
                            state_r  <= RUN;
                            paused_r <= 1'b0;
                            if (step_s) begin
                                if (count_r == period_sh_r) begin
                                    tick_r <= 1'b1;
                                    if (reload_sh_r) begin
                                        count_r <= {WIDTH{1'b0}};
                                    end else begin
                                        state_r <= IDLE;
                                        busy_r  <= 1'b0;
                                        done_r  <= 1'b1;
                                    end
                                end else begin
                                    count_r <= count_r + WIDTH'(1);
                                end
                            end else begin
                                count_r <= count_r;
                            end
                        end
                    end
                    default: begin
                        state_r  <= IDLE;
                        busy_r   <= 1'b0;
                        paused_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign count_out = count_r;
    assign busy      = busy_r;
    assign paused    = paused_r;
    assign tick      = tick_r;
    assign done      = done_r;

endmodule

// File: tb/tb_counter_sched.sv
// Directed bench for counter_sched: per-cycle expectations queued as stimulus is
// driven, then popped and checked just after the following clock edge.
module tb_counter_sched;

    logic        clk;
    logic        rstn;
    logic        start;
    logic        stop;
    logic        hold;
    logic        auto_reload;
    logic [15:0] period;
    logic [7:0]  prescale;
    logic [15:0] count_out;
    logic        busy;
    logic        paused;
    logic        tick;
    logic        done;

    typedef struct {
        logic [19:0] v;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    counter_sched #(.WIDTH(16), .PRESC_W(8)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .stop        (stop),
        .hold        (hold),
        .auto_reload (auto_reload),
        .period      (period),
        .prescale    (prescale),
        .count_out   (count_out),
        .busy        (busy),
        .paused      (paused),
        .tick        (tick),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare_head();
        exp_t e;
        logic [19:0] obs;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL scoreboard_empty: observed 0 entries, expected 1");
        end else begin
            e   = sb.pop_front();
            obs = {count_out, busy, paused, tick, done};
            tests++;
            assert (obs === e.v) else begin
                fails++;
                $error("FAIL %s: observed cnt=%0d b/p/t/d=%b expected cnt=%0d b/p/t/d=%b",
                       e.tag, obs[19:4], obs[3:0], e.v[19:4], e.v[3:0]);
            end
        end
    endtask

    // Drive one cycle of controls, queue the outputs expected after the edge, check them.
    task automatic cyc(input logic s, input logic sp, input logic h,
                       input logic [15:0] ec, input logic eb, input logic ep,
                       input logic et, input logic ed, input string tag);
        exp_t e;
        start = s;
        stop  = sp;
        hold  = h;
        e.v   = {ec, eb, ep, et, ed};
        e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_head();
    endtask

    // Check current outputs without a clock edge (asynchronous reset).
    task automatic chk_now(input logic [15:0] ec, input logic eb, input logic ep,
                           input logic et, input logic ed, input string tag);
        exp_t e;
        e.v   = {ec, eb, ep, et, ed};
        e.tag = tag;
        sb.push_back(e);
        compare_head();
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; stop = 1'b0; hold = 1'b0;
        auto_reload = 1'b0; period = 16'd0; prescale = 8'd0;
        #12;
        chk_now(16'd0, 1'b0, 1'b0, 1'b0, 1'b0, "reset_state");
        @(negedge clk);
        rstn = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, "idle_after_reset");

        // Reset mid-RUN at count 5.
        period = 16'd10; prescale = 8'd0; auto_reload = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, "rst_start");
        for (int k = 1; k <= 5; k++)
            cyc(1'b0, 1'b0, 1'b0, 16'(k), 1'b1, 1'b0, 1'b0, 1'b0, "rst_count");
        rstn = 1'b0;
        #1;
        chk_now(16'd0, 1'b0, 1'b0, 1'b0, 1'b0, "rst_async");
        @(negedge clk);
        rstn = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, "rst_stays_idle");
        cyc(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, "rst_stays_idle2");

        // Auto-reload, period 3, prescale 0: tick every 4 cycles.
        period = 16'd3; prescale = 8'd0; auto_reload = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, "ar_start");
        for (int k = 1; k <= 12; k++)
            cyc(1'b0, 1'b0, 1'b0, 16'(k % 4), 1'b1, 1'b0, (k % 4) == 0, 1'b0, "ar_seq");
        cyc(1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, "ar_stop");

        // One-shot, period 2, prescale 2; config changed mid-run must be ignored.
        period = 16'd2; prescale = 8'd2; auto_reload = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, "os_start");
        period = 16'd0; prescale = 8'd0; auto_reload = 1'b1;
        for (int k = 1; k <= 8; k++)
            cyc(1'b0, 1'b0, 1'b0, 16'(k / 3), 1'b1, 1'b0, 1'b0, 1'b0, "os_seq");
        cyc(1'b0, 1'b0, 1'b0, 16'd2, 1'b0, 1'b0, 1'b1, 1'b1, "os_done");
        cyc(1'b0, 1'b0, 1'b0, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0, "os_idle_hold");
        cyc(1'b0, 1'b0, 1'b1, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0, "idle_hold_ignored");

        // Hold for 3 cycles at count 4, period 7.
        period = 16'd7; prescale = 8'd0; auto_reload = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, "hold_start");
        for (int k = 1; k <= 4; k++)
            cyc(1'b0, 1'b0, 1'b0, 16'(k), 1'b1, 1'b0, 1'b0, 1'b0, "hold_pre");
        for (int k = 0; k < 3; k++)
            cyc(1'b0, 1'b0, 1'b1, 16'd4, 1'b1, 1'b1, 1'b0, 1'b0, "hold_paused");
        for (int k = 5; k <= 7; k++)
            cyc(1'b0, 1'b0, 1'b0, 16'(k), 1'b1, 1'b0, 1'b0, 1'b0, "hold_resume");
        cyc(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0, "hold_tick");

        // Simultaneous start+stop: stop wins, no restart.
        cyc(1'b0, 1'b0, 1'b0, 16'd1, 1'b1, 1'b0, 1'b0, 1'b0, "ss_run");
        cyc(1'b1, 1'b1, 1'b0, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0, "ss_stop_wins");
        cyc(1'b0, 1'b0, 1'b0, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0, "ss_no_restart");

        // Stop coinciding with a terminal step suppresses the tick.
        period = 16'd2; prescale = 8'd0; auto_reload = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, "ts_start");
        cyc(1'b0, 1'b0, 1'b0, 16'd1, 1'b1, 1'b0, 1'b0, 1'b0, "ts_c1");
        cyc(1'b0, 1'b0, 1'b0, 16'd2, 1'b1, 1'b0, 1'b0, 1'b0, "ts_c2");
        cyc(1'b0, 1'b1, 1'b0, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0, "ts_stop_no_tick");
        cyc(1'b0, 1'b0, 1'b0, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0, "ts_after");

        // Restart at count 5 with a new period of 1.
        period = 16'd10; prescale = 8'd0; auto_reload = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, "rs_start");
        for (int k = 1; k <= 5; k++)
            cyc(1'b0, 1'b0, 1'b0, 16'(k), 1'b1, 1'b0, 1'b0, 1'b0, "rs_count");
        period = 16'd1;
        cyc(1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, "rs_restart");
        cyc(1'b0, 1'b0, 1'b0, 16'd1, 1'b1, 1'b0, 1'b0, 1'b0, "rs_c1");
        cyc(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0, "rs_tick");

        // Period 0 auto-reload: tick every cycle.
        period = 16'd0;
        cyc(1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, "p0_start");
        for (int k = 0; k < 4; k++)
            cyc(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0, "p0_tick");
        cyc(1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, "p0_stop");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
